// File: rtl/shift_pkg.sv
// shift_pkg: shared FSM state and bit-order encodings for the serial word receiver
package shift_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;
endpackage

// File: rtl/serial_word_shift_core.sv
// serial_word_shift_core: WIDTH-bit bidirectional assembly register
// ports: en_i shift enable, order_i bit order, bit_i serial bit, clr_i discard old contents,
//        word_d_o value the register takes at the next edge
module serial_word_shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             order_i,
  input  logic             bit_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] word_d_o
);
  logic [WIDTH-1:0] word_q, base;
  always_comb begin
    base = clr_i ? '0 : word_q;
    word_d_o = !en_i ? word_q
             : (order_i == ORDER_LSB) ? {bit_i, base[WIDTH-1:1]}
             : {base[WIDTH-2:0], bit_i};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) word_q <= '0;
    else       word_q <= word_d_o;
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: framed serial-to-parallel receiver with one-deep valid/ready output buffer
// ports: ser_in/ser_valid/frame/lsb_first serial side; out_data/out_valid/out_ready parallel side;
//        busy word in progress; overrun one-cycle pulse when a completed word is dropped
module serial_word_receiver
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             order_q, order_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, word_d;
  logic             out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic             start, adv, done, full;
  // a framed strobe always begins a new word, even mid-word (restart)
  assign start = ser_valid && frame;
  assign adv   = ser_valid && !start && (state_q == ST_SHIFT);
  assign done  = adv && (cnt_q == CW'(WIDTH - 1));
  assign full  = out_valid_q && !out_ready;
  serial_word_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .en_i    (start || adv),
    .order_i (start ? lsb_first : order_q),
    .bit_i   (ser_in),
    .clr_i   (start),
    .word_d_o(word_d)
  );
  always_comb begin
    state_d     = start ? ST_SHIFT : done ? ST_IDLE : state_q;
    cnt_d       = start ? CW'(1) : adv ? cnt_q + CW'(1) : cnt_q;
    order_d     = start ? lsb_first : order_q;
    out_valid_d = done || full;
    out_data_d  = (done && !full) ? word_d : out_data_q;
    overrun_d   = done && full;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      order_q     <= ORDER_MSB;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      order_q     <= order_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_SHIFT);
  assign overrun   = overrun_q;
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-in, parallel-out receiver for the bitstream produced by the team's universal shift registers when they run in serial-shift mode. It collects a framed run of `WIDTH` serial bits, MSB-first or LSB-first, into a parallel word. It presents the word through a one-deep valid/ready output buffer, so a parallel consumer can take words back-to-back.

## Interface
- `WIDTH`, 4, word length in bits; legal range 2..32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `ser_in` input 1: serial data bit, sampled only when `ser_valid`=1.
- `ser_valid` input 1: bit strobe.
- `frame` input 1: qualifies the bit sampled with it as bit 0 of a new word. Ignored when `ser_valid`=0.
- `lsb_first` input 1: bit order. Sampled only with the framing bit and held for that word.
- `out_data` output WIDTH: assembled word.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word at an edge where `out_valid`&&`out_ready`.
- `busy` output 1: a word is partially received (state SHIFT).
- `overrun` output 1: one-cycle pulse; a completed word was dropped because the buffer was full.

## Operation
- FSM states:
  - IDLE: `ser_valid`&&`frame` → SHIFT with `cnt`=1. The bit is shifted into the assembly register, and `lsb_first` is latched into `order_q`. Strobes without `frame` are ignored.
  - SHIFT: each `ser_valid` shifts one bit and increments `cnt`. When the strobe makes `cnt`==`WIDTH`, the word is complete and the FSM returns to IDLE.
- Restart: `ser_valid`&&`frame` in SHIFT discards the partial word. That bit becomes bit 0 of a new word: `cnt`=1 and `order_q` is re-latched. No output and no overrun result.
- Bit order:
  - MSB-first (`order_q`=0): shift left, `ser_in` enters bit 0. The first bit ends in bit `WIDTH-1`.
  - LSB-first (`order_q`=1): shift right, `ser_in` enters bit `WIDTH-1`. The first bit ends in bit 0.
- Completion, with the buffer empty or being consumed at the same edge: load `out_data` and set/keep `out_valid`=1.
- Completion with `out_valid`=1 and `out_ready`=0: the new word is dropped, `out_data` is unchanged, and `overrun`=1 for exactly that cycle.
- Consume with no completion at the same edge: `out_valid` clears; `out_data` holds its stale value.
- Gaps of any length between strobes are legal; `busy` stays 1 through them.
- `cnt` width is clog2(`WIDTH`+1). `cnt` never exceeds `WIDTH`.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0, FSM=IDLE, `cnt`=0, assembly register=0. Reset takes effect immediately and asynchronously, including mid-word; the partial word is lost.
- Latency: a word sampled with its last bit at edge N shows `out_valid`=1 and the new `out_data` after edge N. There are zero extra cycles.
- Throughput: one bit per cycle. A `frame` bit may arrive the cycle right after a completing bit, so the next word starts with no idle cycle.
- `overrun` is registered; it is high for the single cycle following the dropping edge.
- `busy` is registered. It rises after the framing edge and falls after the completing edge.
- `out_ready` has no effect while `out_valid`=0.

## Structure
- Shared package `shift_pkg`:
  - FSM state encodings `ST_IDLE`=1'b0, `ST_SHIFT`=1'b1.
  - Bit-order constants `ORDER_MSB`=0, `ORDER_LSB`=1.
- One natural sub-module, `serial_word_shift_core`: the `WIDTH`-bit bidirectional assembly register. Its inputs are shift-enable, order, serial bit and clear.
- FSM, counter and output buffer live in the top module.

## Test plan
- `WIDTH`=4, MSB-first: frame+bits 1,0,1,1 on consecutive cycles → `out_data`=4'b1011, `out_valid` high after the 4th edge, `busy` low.
- Same bits with `lsb_first`=1 → `out_data`=4'b1101.
- Bits 0,1,1,0 MSB-first with 3 idle cycles between each strobe → `out_data`=4'b0110. `busy`=1 for the whole span; no early `out_valid`.
- `out_ready`=0, words 4'hA then 4'h5 back-to-back → `out_data` stays 4'hA. `overrun` pulses once after the 8th bit. Raising `out_ready` clears `out_valid`.
- Frame + bits 1,1, then frame + bits 1,1,0,0 → exactly one word, 4'b1100. No overrun.
- Assert `reset` asynchronously mid-clock after 2 bits of a word → all outputs 0 immediately. The next framed 1,0,0,1 yields 4'b1001.
